sram_access_seq: RTL

- Multi-cycle memory access sequencer between the SLC-3 datapath (MAR/MDR) and the external 1Mx16 SRAM tristate interface.
- Accepts one read or write request at a time, generates active-low SRAM strobes with programmable wait states, and returns read data with a one-cycle Done pulse that the ISDU uses to leave its memory-wait states.
- Decodes one memory-mapped I/O address: reads return the switches, writes update a hex-display register. Accesses to that address never reach SRAM.

---
 rtl/sram_access_seq_if.sv | 61 ++++++
 rtl/sram_access_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sram_access_seq_if.sv
// SLC-3 memory sequencer bus: datapath request side plus SRAM/board pins.
// slave = sequencer view, master = datapath/board view.
interface sram_access_seq_if;
  logic        Req;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] Wdata;
  logic [15:0] Switches;
  logic [15:0] Data_from_SRAM;
  logic [15:0] Rdata;
  logic        Done;
  logic        Busy;
  logic        CE;
  logic        OE;
  logic        WE;
  logic        UB;
  logic        LB;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic [15:0] HEX_Data;

  modport slave (
    input  Req,
    input  Wr,
    input  Addr,
    input  Wdata,
    input  Switches,
    input  Data_from_SRAM,
    output Rdata,
    output Done,
    output Busy,
    output CE,
    output OE,
    output WE,
    output UB,
    output LB,
    output ADDR,
    output Data_to_SRAM,
    output HEX_Data
  );

  modport master (
    output Req,
    output Wr,
    output Addr,
    output Wdata,
    output Switches,
    output Data_from_SRAM,
    input  Rdata,
    input  Done,
    input  Busy,
    input  CE,
    input  OE,
    input  WE,
    input  UB,
    input  LB,
    input  ADDR,
    input  Data_to_SRAM,
    input  HEX_Data
  );
endinterface

// File: rtl/sram_access_seq.sv
// Multi-cycle SRAM access sequencer with wait states and one I/O address.
// All strobes and status outputs come straight from flops.
module sram_access_seq #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input logic               Clk,
  input logic               Reset,
  sram_access_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic        r_io;
  logic [19:0] r_addr;
  logic [15:0] r_dts;
  logic [15:0] r_rdata;
  logic [15:0] r_hex;
  logic        r_ce;
  logic        r_oe;
  logic        r_we;
  logic        r_ub;
  logic        r_lb;
  logic        r_done;
  logic        r_busy;

  logic        w_io_req;

  assign w_io_req = (bus.Addr == IO_ADDR);

  // Sequencer FSM; every output is registered here
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_io    <= 1'b0;
      r_addr  <= '0;
      r_dts   <= '0;
      r_rdata <= '0;
      r_hex   <= '0;
      r_ce    <= 1'b1;
      r_oe    <= 1'b1;
      r_we    <= 1'b1;
      r_ub    <= 1'b1;
      r_lb    <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.Req) begin
            r_wr    <= bus.Wr;
            r_io    <= w_io_req;
            r_addr  <= {4'h0, bus.Addr};
            r_dts   <= bus.Wdata;
            r_ce    <= w_io_req;
            r_ub    <= w_io_req;
            r_lb    <= w_io_req;
            r_oe    <= w_io_req | bus.Wr;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt   <= '0;
          r_we    <= r_io | ~r_wr;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_cnt == LAST) begin
            r_ce    <= 1'b1;
            r_oe    <= 1'b1;
            r_we    <= 1'b1;
            r_ub    <= 1'b1;
            r_lb    <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
            if (!r_wr) begin
              r_rdata <= r_io ? bus.Switches
                              : bus.Data_from_SRAM;
            end else if (r_io) begin
              r_hex <= r_dts;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Rdata        = r_rdata;
  assign bus.Done         = r_done;
  assign bus.Busy         = r_busy;
  assign bus.CE           = r_ce;
  assign bus.OE           = r_oe;
  assign bus.WE           = r_we;
  assign bus.UB           = r_ub;
  assign bus.LB           = r_lb;
  assign bus.ADDR         = r_addr;
  assign bus.Data_to_SRAM = r_dts;
  assign bus.HEX_Data     = r_hex;

endmodule
